// File: rtl/rf_pkg.sv
// rf_pkg: register-file widths, write record and write-arbiter state encoding
package rf_pkg;
   localparam int RF_AW = 2;
   localparam int RF_DW = 8;
   localparam int RF_NREG = 1 << RF_AW;
   typedef logic [RF_AW-1:0] rf_addr_t;
   typedef logic [RF_DW-1:0] rf_data_t;
   typedef struct packed {
      rf_addr_t addr;
      rf_data_t data;
   } rf_wr_t;
   typedef enum logic [1:0] {EMPTY, ISSUE, HOLD} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after i_ptr
module rr_arbiter #(
   parameter int N = 3,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);
   logic [IW-1:0] w_j;
   always_comb begin
      o_grant = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_j = '0;
      // walk offsets from farthest to nearest so the nearest requester overwrites
      for (int k = N - 1; k >= 0; k--) begin
         w_j = IW'((int'(i_ptr) + k) % N);
         if (i_req[w_j]) begin
            o_grant = '0;
            o_grant[w_j] = 1'b1;
            o_idx = w_j;
            o_any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin sharing of the register-file write port through a registered issue stage.
// Define RF_ARB_STATS_EN to add stat_sel/stat_count and per-requester saturating accept counters.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DW = RF_DW,
   parameter int AW = RF_AW,
   localparam int IW = $clog2(NUM_REQ),
   localparam int NR = 1 << AW
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ*DW-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic                  stall,
   output logic                  write_enable,
   output logic [AW-1:0]         write_addr,
   output logic [DW-1:0]         write_data,
   output logic [IW-1:0]         grant_id,
   output logic [NR-1:0]         pending_mask
`ifdef RF_ARB_STATS_EN
   ,
   input  logic [IW-1:0]         stat_sel,
   output logic [7:0]            stat_count
`endif
);
   arb_state_t r_state, w_state_nxt;
   logic [IW-1:0] r_ptr, r_id, w_idx;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data;
   logic [NUM_REQ-1:0] w_grant;
   logic w_any, w_valid, w_acc;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .i_req(req_valid),
      .i_ptr(r_ptr),
      .o_grant(w_grant),
      .o_idx(w_idx),
      .o_any(w_any)
   );

   assign w_valid = r_state != EMPTY;
   assign w_acc = w_any & ~stall;
   assign req_ready = (stall | reset) ? '0 : w_grant;
   assign write_enable = w_valid & ~stall;
   assign write_addr = r_addr;
   assign write_data = r_data;
   assign grant_id = r_id;
   assign pending_mask = w_valid ? NR'(1) << r_addr : '0;

   // a stalled entry is kept; otherwise the stage refills or drains every cycle
   always_comb w_state_nxt = stall ? (w_valid ? HOLD : EMPTY) : (w_acc ? ISSUE : EMPTY);

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state <= EMPTY;
         r_ptr <= '0;
         r_id <= '0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_acc) begin
            r_addr <= req_addr[w_idx*AW +: AW];
            r_data <= req_data[w_idx*DW +: DW];
            r_id <= w_idx;
            r_ptr <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
         end
      end

`ifdef RF_ARB_STATS_EN
   logic [7:0] r_cnt [NUM_REQ];
   always_ff @(posedge clk or posedge reset)
      if (reset) r_cnt <= '{default: '0};
      else if (w_acc && r_cnt[w_idx] != 8'hFF) r_cnt[w_idx] <= r_cnt[w_idx] + 8'd1;
   assign stat_count = (int'(stat_sel) < NUM_REQ) ? r_cnt[stat_sel] : '0;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: vector table, directed corner sequences and randomized model check
module tb_rf_write_arbiter;
   logic clk = 1'b0, reset = 1'b1, stall = 1'b0;
   logic [2:0] req_valid = '0;
   logic [5:0] req_addr = '0;
   logic [23:0] req_data = '0;
   logic [2:0] req_ready;
   logic write_enable;
   logic [1:0] write_addr, grant_id;
   logic [7:0] write_data;
   logic [3:0] pending_mask;
`ifdef RF_ARB_STATS_EN
   logic [1:0] stat_sel = '0;
   logic [7:0] stat_count;
`endif
   int n_tests = 0, n_fail = 0, n_wr = 0;
   logic [7:0] tb_rf [4] = '{default: 8'h00};

   typedef struct {
      logic [2:0] v; logic [5:0] a; logic [23:0] d; logic st;
      logic [2:0] rdy; logic we; logic [1:0] wa; logic [7:0] wd; logic [3:0] pm;
   } vec_t;

   always #5 clk = ~clk;

   rf_write_arbiter dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .stall(stall), .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .grant_id(grant_id), .pending_mask(pending_mask)
`ifdef RF_ARB_STATS_EN
      , .stat_sel(stat_sel), .stat_count(stat_count)
`endif
   );

   // register file fed from the write port, as register_file would see it
   always @(posedge clk)
      if (write_enable) begin
         tb_rf[write_addr] <= write_data;
         n_wr <= n_wr + 1;
      end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic [2:0] v, input logic [5:0] a, input logic [23:0] d, input logic st);
      req_valid = v;
      req_addr = a;
      req_data = d;
      stall = st;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      drv(3'b000, 6'h0, 24'h0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      vec_t vec [15];
      logic [2:0] v, e_rdy;
      logic [5:0] a;
      logic [23:0] d;
      logic st, mv, e_we, found;
      logic [1:0] ma, mid;
      logic [7:0] md;
      logic [7:0] m_rf [4];
      int ptr, g, w0;
      vec[0]  = '{3'b001, 6'b000001, 24'h00003C, 1'b0, 3'b001, 1'b0, 2'd0, 8'h00, 4'b0000};
      vec[1]  = '{3'b000, 6'b000000, 24'h000000, 1'b0, 3'b000, 1'b1, 2'd1, 8'h3C, 4'b0010};
      vec[2]  = '{3'b000, 6'b000000, 24'h000000, 1'b0, 3'b000, 1'b0, 2'd0, 8'h00, 4'b0000};
      vec[3]  = '{3'b111, 6'b100100, 24'hA2A1A0, 1'b0, 3'b010, 1'b0, 2'd0, 8'h00, 4'b0000};
      vec[4]  = '{3'b111, 6'b100100, 24'hA2A1A0, 1'b0, 3'b100, 1'b1, 2'd1, 8'hA1, 4'b0010};
      vec[5]  = '{3'b111, 6'b100100, 24'hA2A1A0, 1'b0, 3'b001, 1'b1, 2'd2, 8'hA2, 4'b0100};
      vec[6]  = '{3'b000, 6'b000000, 24'h000000, 1'b0, 3'b000, 1'b1, 2'd0, 8'hA0, 4'b0001};
      vec[7]  = '{3'b010, 6'b001100, 24'h005500, 1'b0, 3'b010, 1'b0, 2'd0, 8'h00, 4'b0000};
      vec[8]  = '{3'b110, 6'b000000, 24'h221100, 1'b0, 3'b100, 1'b1, 2'd3, 8'h55, 4'b1000};
      vec[9]  = '{3'b010, 6'b000000, 24'h221100, 1'b0, 3'b010, 1'b1, 2'd0, 8'h22, 4'b0001};
      vec[10] = '{3'b000, 6'b000000, 24'h000000, 1'b0, 3'b000, 1'b1, 2'd0, 8'h11, 4'b0001};
      vec[11] = '{3'b000, 6'b000000, 24'h000000, 1'b0, 3'b000, 1'b0, 2'd0, 8'h00, 4'b0000};
      vec[12] = '{3'b001, 6'b000010, 24'h000099, 1'b1, 3'b000, 1'b0, 2'd0, 8'h00, 4'b0000};
      vec[13] = '{3'b001, 6'b000010, 24'h000099, 1'b0, 3'b001, 1'b0, 2'd0, 8'h00, 4'b0000};
      vec[14] = '{3'b000, 6'b000000, 24'h000000, 1'b0, 3'b000, 1'b1, 2'd2, 8'h99, 4'b0100};

      do_reset();
      #1;
      chk("reset we", 32'(write_enable), 32'd0);
      chk("reset wa", 32'(write_addr), 32'd0);
      chk("reset wd", 32'(write_data), 32'd0);
      chk("reset gid", 32'(grant_id), 32'd0);
      chk("reset pm", 32'(pending_mask), 32'd0);
      chk("reset rdy", 32'(req_ready), 32'd0);

      // reset while an entry is in the issue stage
      @(negedge clk);
      drv(3'b001, 6'b000010, 24'h0000A5, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("midrst we", 32'(write_enable), 32'd1);
      chk("midrst pm", 32'(pending_mask), 32'b0100);
      #2 reset = 1'b1;
      #1;
      chk("rst we", 32'(write_enable), 32'd0);
      chk("rst wa", 32'(write_addr), 32'd0);
      chk("rst wd", 32'(write_data), 32'd0);
      chk("rst gid", 32'(grant_id), 32'd0);
      chk("rst pm", 32'(pending_mask), 32'd0);
      chk("rst rdy", 32'(req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      drv(3'b000, 6'h0, 24'h0, 1'b0);
      #1 chk("rst no write r2", 32'(tb_rf[2]), 32'd0);

      // all sources valid from reset
      do_reset();
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         drv(3'b111, 6'b100100, 24'hA2A1A0, 1'b0);
         #1;
         chk($sformatf("rr%0d rdy", k), 32'(req_ready), 32'(3'b001 << (k % 3)));
         chk($sformatf("rr%0d we", k), 32'(write_enable), 32'(k > 0));
         if (k > 0) begin
            chk($sformatf("rr%0d gid", k), 32'(grant_id), 32'((k - 1) % 3));
            chk($sformatf("rr%0d wd", k), 32'(write_data), 32'(8'hA0 + (k - 1) % 3));
         end
         @(posedge clk);
      end

      // stall with {r3,7E} in the issue stage
      do_reset();
      @(negedge clk);
      drv(3'b001, 6'b000011, 24'h00007E, 1'b0);
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drv(3'b010, 6'b000100, 24'h004200, 1'b1);
         #1;
         chk($sformatf("stall%0d we", k), 32'(write_enable), 32'd0);
         chk($sformatf("stall%0d rdy", k), 32'(req_ready), 32'd0);
         chk($sformatf("stall%0d pm", k), 32'(pending_mask), 32'b1000);
         @(posedge clk);
      end
      w0 = n_wr;
      @(negedge clk);
      drv(3'b010, 6'b000100, 24'h004200, 1'b0);
      #1;
      chk("release we", 32'(write_enable), 32'd1);
      chk("release wa", 32'(write_addr), 32'd3);
      chk("release wd", 32'(write_data), 32'h7E);
      chk("release rdy", 32'(req_ready), 32'b010);
      @(posedge clk);
      @(negedge clk);
      drv(3'b000, 6'h0, 24'h0, 1'b0);
      #1;
      chk("after wa", 32'(write_addr), 32'd1);
      chk("after wd", 32'(write_data), 32'h42);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("drain we", 32'(write_enable), 32'd0);
      chk("stall r3", 32'(tb_rf[3]), 32'h7E);
      chk("stall writes", 32'(n_wr - w0), 32'd2);

      // vector table
      do_reset();
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         drv(vec[i].v, vec[i].a, vec[i].d, vec[i].st);
         #1;
         chk($sformatf("vec%0d rdy", i), 32'(req_ready), 32'(vec[i].rdy));
         chk($sformatf("vec%0d we", i), 32'(write_enable), 32'(vec[i].we));
         chk($sformatf("vec%0d pm", i), 32'(pending_mask), 32'(vec[i].pm));
         if (vec[i].we) begin
            chk($sformatf("vec%0d wa", i), 32'(write_addr), 32'(vec[i].wa));
            chk($sformatf("vec%0d wd", i), 32'(write_data), 32'(vec[i].wd));
         end
         if (i == 2) chk("single r1", 32'(tb_rf[1]), 32'h3C);
         @(posedge clk);
      end
      @(negedge clk);
      drv(3'b000, 6'h0, 24'h0, 1'b0);
      #1;
      chk("vec r0", 32'(tb_rf[0]), 32'h11);
      chk("vec r1", 32'(tb_rf[1]), 32'hA1);
      chk("vec r2", 32'(tb_rf[2]), 32'h99);
      chk("vec r3", 32'(tb_rf[3]), 32'h55);

      // randomized traffic against the reference model
      do_reset();
      #1;
      for (int r = 0; r < 4; r++) m_rf[r] = tb_rf[r];
      mv = 1'b0; ma = '0; md = '0; mid = '0; ptr = 0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         v = 3'($urandom);
         a = 6'($urandom);
         d = 24'($urandom);
         st = ($urandom_range(0, 4) == 0);
         drv(v, a, d, st);
         #1;
         e_rdy = '0;
         found = 1'b0;
         g = 0;
         if (!st)
            for (int k = 0; k < 3; k++)
               if (!found && v[(ptr + k) % 3]) begin
                  found = 1'b1;
                  g = (ptr + k) % 3;
                  e_rdy[g] = 1'b1;
               end
         e_we = mv & ~st;
         chk("rnd rdy", 32'(req_ready), 32'(e_rdy));
         chk("rnd we", 32'(write_enable), 32'(e_we));
         chk("rnd pm", 32'(pending_mask), mv ? 32'(4'b0001 << ma) : 32'd0);
         if (e_we) begin
            chk("rnd wa", 32'(write_addr), 32'(ma));
            chk("rnd wd", 32'(write_data), 32'(md));
            chk("rnd gid", 32'(grant_id), 32'(mid));
         end
         @(posedge clk);
         if (e_we) m_rf[ma] = md;
         if (found) begin
            mv = 1'b1;
            ma = a[g*2 +: 2];
            md = d[g*8 +: 8];
            mid = 2'(g);
            ptr = (g + 1) % 3;
         end else if (!st) mv = 1'b0;
      end
      @(negedge clk);
      drv(3'b000, 6'h0, 24'h0, 1'b1);
      #1;
      for (int r = 0; r < 4; r++) chk($sformatf("rnd rf%0d", r), 32'(tb_rf[r]), 32'(m_rf[r]));

`ifdef RF_ARB_STATS_EN
      do_reset();
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         drv(3'b010, 6'b000100, 24'h000100, 1'b0);
         @(posedge clk);
      end
      @(negedge clk);
      drv(3'b000, 6'h0, 24'h0, 1'b0);
      stat_sel = 2'd1;
      #1 chk("stat sel1", 32'(stat_count), 32'd255);
      stat_sel = 2'd0;
      #1 chk("stat sel0", 32'(stat_count), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
